// File: rtl/cpu_checker_pkg.sv
// Shared constants and character helpers for the cpu_checker_v2 trace parser.
package cpu_checker_pkg;

  localparam logic [3:0] S_IDLE = 4'd0,  S_TIME = 4'd1, S_PC   = 4'd2,
                         S_SP0  = 4'd3,  S_GRF  = 4'd4, S_ADDR = 4'd5,
                         S_SP1  = 4'd6,  S_LT   = 4'd7, S_SP2  = 4'd8,
                         S_DATA = 4'd9,  S_DONE = 4'd10;

  localparam int ERR_TIME = 0, ERR_PC = 1, ERR_ADDR = 2, ERR_GRF = 3, ERR_MONO = 4;

  localparam logic [1:0] FMT_NONE = 2'd0, FMT_REG = 2'd1, FMT_MEM = 2'd2;

  function automatic logic is_dec(input logic [7:0] c);
    return (c >= 8'h30) && (c <= 8'h39);
  endfunction

  // lowercase only: uppercase hex is a format error
  function automatic logic is_hex(input logic [7:0] c);
    return is_dec(c) || ((c >= 8'h61) && (c <= 8'h66));
  endfunction

  function automatic logic [3:0] hex_val(input logic [7:0] c);
    return is_dec(c) ? c[3:0] : c[3:0] + 4'd9;
  endfunction

  // wrap-around subtraction folds both bounds into one compare
  function automatic logic in_win(input logic [31:0] v, input logic [31:0] lo,
                                  input logic [31:0] hi);
    return (v - lo) <= (hi - lo);
  endfunction

endpackage

// File: rtl/char_class.sv
// Combinational character classifier: decimal/hex flags and nibble value.
module char_class
  import cpu_checker_pkg::*;
(
  input  logic [7:0] ch,
  output logic       dec,
  output logic       hex,
  output logic [3:0] nib
);
  assign dec = is_dec(ch);
  assign hex = is_hex(ch);
  assign nib = hex_val(ch);
endmodule

// File: rtl/cpu_checker_v2.sv
// Character-stream trace checker: parses register/memory write records and flags
// format and semantic errors, with time-monotonicity history and saturating stats.
module cpu_checker_v2
  import cpu_checker_pkg::*;
#(
  parameter int          TIME_DIGITS = 4,
  parameter int          GRF_DIGITS  = 4,
  parameter int          REG_NUM     = 32,
  parameter logic [31:0] PC_LO       = 32'h0000_3000,
  parameter logic [31:0] PC_HI       = 32'h0000_6FFF,
  parameter logic [31:0] ADDR_LO     = 32'h0,
  parameter logic [31:0] ADDR_HI     = 32'h0000_2FFF,
  parameter int          CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       char,
  input  logic [15:0]      freq,
  output logic [1:0]       format_type,
  output logic [4:0]       error_code,
  output logic [CNT_W-1:0] record_cnt,
  output logic [CNT_W-1:0] err_cnt
);
  localparam int TIME_W = $clog2(10**TIME_DIGITS);
  localparam int GRF_W  = $clog2(10**GRF_DIGITS);

  logic [3:0]        state;
  logic [7:0]        cnt;
  logic [TIME_W-1:0] tm_acc, prev_time;
  logic [GRF_W-1:0]  grf_acc;
  logic [31:0]       pc_acc, addr_acc;
  logic              is_mem, prev_valid;
  logic [4:0]        err_q, err_new;
  logic [31:0]       tmask;
  logic              c_dec, c_hex;
  logic [3:0]        c_nib;

  char_class u_cc (.ch(char), .dec(c_dec), .hex(c_hex), .nib(c_nib));

  assign tmask = 32'(freq >> 1) - 32'd1;

  always_comb begin
    err_new           = '0;
    err_new[ERR_TIME] = (32'(tm_acc) & tmask) != 32'd0;
    err_new[ERR_PC]   = !in_win(pc_acc, PC_LO, PC_HI) || (pc_acc[1:0] != 2'b00);
    err_new[ERR_ADDR] = is_mem && (!in_win(addr_acc, ADDR_LO, ADDR_HI) || (addr_acc[1:0] != 2'b00));
    err_new[ERR_GRF]  = !is_mem && (32'(grf_acc) >= 32'(REG_NUM));
    err_new[ERR_MONO] = prev_valid && (tm_acc < prev_time);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      tm_acc     <= '0;
      grf_acc    <= '0;
      pc_acc     <= '0;
      addr_acc   <= '0;
      is_mem     <= 1'b0;
      err_q      <= '0;
      prev_time  <= '0;
      prev_valid <= 1'b0;
      record_cnt <= '0;
      err_cnt    <= '0;
    end else if (char == "^") begin
      state    <= S_TIME;
      cnt      <= '0;
      tm_acc   <= '0;
      grf_acc  <= '0;
      pc_acc   <= '0;
      addr_acc <= '0;
      is_mem   <= 1'b0;
    end else begin
      // anything not matched below is a format error and drops the record
      state <= S_IDLE;
      case (state)
        S_TIME:
          if (c_dec && cnt < 8'(TIME_DIGITS)) begin
            state  <= S_TIME;
            cnt    <= cnt + 8'd1;
            tm_acc <= TIME_W'(tm_acc * TIME_W'(10) + TIME_W'(c_nib));
          end else if (char == "@" && cnt != 8'd0) begin
            state <= S_PC;
            cnt   <= '0;
          end
        S_PC:
          if (c_hex && cnt < 8'd8) begin
            state  <= S_PC;
            cnt    <= cnt + 8'd1;
            pc_acc <= {pc_acc[27:0], c_nib};
          end else if (char == ":" && cnt == 8'd8) begin
            state <= S_SP0;
          end
        S_SP0:
          if (char == " ") begin
            state <= S_SP0;
          end else if (char == "$") begin
            state  <= S_GRF;
            cnt    <= '0;
            is_mem <= 1'b0;
          end else if (char == "*") begin
            state  <= S_ADDR;
            cnt    <= '0;
            is_mem <= 1'b1;
          end
        S_GRF:
          if (c_dec && cnt < 8'(GRF_DIGITS)) begin
            state   <= S_GRF;
            cnt     <= cnt + 8'd1;
            grf_acc <= GRF_W'(grf_acc * GRF_W'(10) + GRF_W'(c_nib));
          end else if (char == " " && cnt != 8'd0) begin
            state <= S_SP1;
          end else if (char == "<" && cnt != 8'd0) begin
            state <= S_LT;
          end
        S_ADDR:
          if (c_hex && cnt < 8'd8) begin
            state    <= S_ADDR;
            cnt      <= cnt + 8'd1;
            addr_acc <= {addr_acc[27:0], c_nib};
          end else if (char == " " && cnt == 8'd8) begin
            state <= S_SP1;
          end else if (char == "<" && cnt == 8'd8) begin
            state <= S_LT;
          end
        S_SP1:
          if (char == " ")      state <= S_SP1;
          else if (char == "<") state <= S_LT;
        S_LT:
          if (char == "=") state <= S_SP2;
        S_SP2:
          if (char == " ") begin
            state <= S_SP2;
          end else if (c_hex) begin
            state <= S_DATA;
            cnt   <= 8'd1;
          end
        S_DATA:
          if (c_hex && cnt < 8'd8) begin
            state <= S_DATA;
            cnt   <= cnt + 8'd1;
          end else if (char == "#" && cnt == 8'd8) begin
            state      <= S_DONE;
            err_q      <= err_new;
            prev_time  <= tm_acc;
            prev_valid <= 1'b1;
            if (record_cnt != '1) record_cnt <= record_cnt + 1'b1;
            if (err_new != '0 && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
          end
        default: ;
      endcase
    end
  end

  assign format_type = (state == S_DONE) ? (is_mem ? FMT_MEM : FMT_REG) : FMT_NONE;
  assign error_code  = (state == S_DONE) ? err_q : 5'd0;

endmodule

// File: tb/tb_cpu_checker_v2.sv
// Directed bench for cpu_checker_v2; counters narrowed to 2 bits to reach saturation.
module tb_cpu_checker_v2;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] ch = 8'h00;
  logic [15:0] freq = 16'd4096;
  logic [1:0] format_type;
  logic [4:0] error_code;
  logic [1:0] record_cnt, err_cnt;
  int tests = 0;
  int fails = 0;

  cpu_checker_v2 #(.CNT_W(2)) dut (
    .clk(clk), .reset(reset), .char(ch), .freq(freq),
    .format_type(format_type), .error_code(error_code),
    .record_cnt(record_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  task automatic do_reset();
    @(negedge clk); reset = 1'b0; ch = 8'h00;
    @(negedge clk);
    @(negedge clk); reset = 1'b1;
  endtask

  // drives one char per cycle; returns at the negedge where the last char's effect is visible
  task automatic send(input string s);
    for (int i = 0; i < s.len(); i++) begin
      @(negedge clk); ch = s[i];
    end
    @(negedge clk); ch = 8'h00;
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests++; if (format_type !== 2'd0) begin fails++; $display("FAIL reset_fmt: got %0d expected 0", format_type); end
    tests++; if (error_code !== 5'd0) begin fails++; $display("FAIL reset_err: got %b expected 00000", error_code); end
    tests++; if (record_cnt !== 2'd0 || err_cnt !== 2'd0) begin fails++; $display("FAIL reset_cnt: got %0d/%0d expected 0/0", record_cnt, err_cnt); end
  endtask

  task automatic test_reg_record();
    do_reset();
    send("^2048@00003000: $5 <= 0000abcd#");
    tests++; if (format_type !== 2'd1) begin fails++; $display("FAIL reg_fmt: got %0d expected 1", format_type); end
    tests++; if (error_code !== 5'b00000) begin fails++; $display("FAIL reg_err: got %b expected 00000", error_code); end
    tests++; if (record_cnt !== 2'd1 || err_cnt !== 2'd0) begin fails++; $display("FAIL reg_cnt: got %0d/%0d expected 1/0", record_cnt, err_cnt); end
    @(negedge clk);
    tests++; if (format_type !== 2'd0 || error_code !== 5'd0) begin fails++; $display("FAIL reg_drop: got %0d/%b expected 0/00000", format_type, error_code); end
  endtask

  task automatic test_mem_record();
    do_reset();
    send("^16@00003002:*00003000<=12345678#");
    tests++; if (format_type !== 2'd2) begin fails++; $display("FAIL mem_fmt: got %0d expected 2", format_type); end
    tests++; if (error_code !== 5'b00111) begin fails++; $display("FAIL mem_err: got %b expected 00111", error_code); end
    tests++; if (record_cnt !== 2'd1 || err_cnt !== 2'd1) begin fails++; $display("FAIL mem_cnt: got %0d/%0d expected 1/1", record_cnt, err_cnt); end
  endtask

  task automatic test_grf_mono();
    do_reset();
    send("^4096@00003000: $32 <= 00000000#");
    tests++; if (error_code !== 5'b01000) begin fails++; $display("FAIL grf_err: got %b expected 01000", error_code); end
    send("^2048@00003004: $1 <= 00000000#");
    tests++; if (error_code !== 5'b10000) begin fails++; $display("FAIL mono_err: got %b expected 10000", error_code); end
    tests++; if (record_cnt !== 2'd2 || err_cnt !== 2'd2) begin fails++; $display("FAIL mono_cnt: got %0d/%0d expected 2/2", record_cnt, err_cnt); end
  endtask

  task automatic test_malformed();
    string bad [3];
    bad[0] = "^12345@00003000: $1 <= 00000000#";
    bad[1] = "^1@0000300A: $1 <= 00000000#";
    bad[2] = "^1@00003000: $1 < = 00000000#";
    do_reset();
    for (int k = 0; k < 3; k++) begin
      int seen = 0;
      for (int i = 0; i < bad[k].len(); i++) begin
        @(negedge clk);
        if (format_type !== 2'd0) seen++;
        ch = bad[k][i];
      end
      @(negedge clk);
      if (format_type !== 2'd0) seen++;
      ch = 8'h00;
      tests++; if (seen != 0) begin fails++; $display("FAIL malformed_%0d: got %0d cycles with format_type!=0 expected 0", k, seen); end
    end
    tests++; if (record_cnt !== 2'd0 || err_cnt !== 2'd0) begin fails++; $display("FAIL malformed_cnt: got %0d/%0d expected 0/0", record_cnt, err_cnt); end
  endtask

  task automatic test_restart();
    do_reset();
    send("^1@00^2048@00003000: $0 <= 00000000#");
    tests++; if (format_type !== 2'd1 || error_code !== 5'd0) begin fails++; $display("FAIL restart_out: got %0d/%b expected 1/00000", format_type, error_code); end
    tests++; if (record_cnt !== 2'd1) begin fails++; $display("FAIL restart_cnt: got %0d expected 1", record_cnt); end
  endtask

  task automatic test_back_to_back();
    string a, b, s;
    a = "^4096@00003000: $1 <= 00000000#";
    b = "^2048@00003000: $1 <= 00000000#";
    s = {a, b};
    do_reset();
    for (int i = 0; i < s.len(); i++) begin
      @(negedge clk);
      if (i == a.len()) begin
        tests++; if (format_type !== 2'd1 || error_code !== 5'd0) begin fails++; $display("FAIL b2b_first: got %0d/%b expected 1/00000", format_type, error_code); end
      end
      ch = s[i];
    end
    @(negedge clk); ch = 8'h00;
    tests++; if (format_type !== 2'd1 || error_code !== 5'b10000) begin fails++; $display("FAIL b2b_second: got %0d/%b expected 1/10000", format_type, error_code); end
    tests++; if (record_cnt !== 2'd2) begin fails++; $display("FAIL b2b_cnt: got %0d expected 2", record_cnt); end
  endtask

  task automatic test_async_reset();
    string p;
    p = "^100@00003000: $1 <= 0000";
    do_reset();
    send("^4096@00003000: $1 <= 00000000#");
    tests++; if (record_cnt !== 2'd1) begin fails++; $display("FAIL areset_pre: got %0d expected 1", record_cnt); end
    for (int i = 0; i < p.len(); i++) begin
      @(negedge clk); ch = p[i];
    end
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    tests++; if (format_type !== 2'd0 || record_cnt !== 2'd0 || err_cnt !== 2'd0) begin fails++; $display("FAIL areset_now: got %0d/%0d/%0d expected 0/0/0", format_type, record_cnt, err_cnt); end
    @(negedge clk); ch = 8'h00; reset = 1'b1;
    send("^2048@00003000: $1 <= 00000000#");
    tests++; if (error_code !== 5'd0 || format_type !== 2'd1) begin fails++; $display("FAIL areset_hist: got %0d/%b expected 1/00000", format_type, error_code); end
    tests++; if (record_cnt !== 2'd1) begin fails++; $display("FAIL areset_cnt: got %0d expected 1", record_cnt); end
  endtask

  task automatic test_saturation();
    do_reset();
    repeat (5) send("^4096@00003000: $40 <= 00000000#");
    tests++; if (error_code !== 5'b01000) begin fails++; $display("FAIL sat_err: got %b expected 01000", error_code); end
    tests++; if (record_cnt !== 2'd3 || err_cnt !== 2'd3) begin fails++; $display("FAIL sat_cnt: got %0d/%0d expected 3/3", record_cnt, err_cnt); end
  endtask

  initial begin
    test_reset();
    test_reg_record();
    test_mem_record();
    test_grf_mono();
    test_malformed();
    test_restart();
    test_back_to_back();
    test_async_reset();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cpu_checker_v2.md
Name: cpu_checker_v2

Overview:
- Next-generation character-stream trace checker for the single-cycle/pipelined CPU verification flow.
- Consumes one ASCII char per clock; parses `^time@pc: $grf <= data#` (register write) or `^time@pc: *addr <= data#` (memory write).
- Reports format and semantic errors for each record.
- Over the previous checker, it adds:
  - parametrised address windows, register count and time width;
  - a cross-record time-monotonicity check;
  - saturating record and error counters.

Parameters:
- TIME_DIGITS, 4, maximum decimal digits of time (min 1).
- GRF_DIGITS, 4, maximum decimal digits of register number (min 1).
- REG_NUM, 32, registers 0..REG_NUM-1 legal.
- PC_LO, 32'h0000_3000, lowest legal PC (inclusive).
- PC_HI, 32'h0000_6FFF, highest legal PC (inclusive).
- ADDR_LO, 32'h0, lowest legal memory address (inclusive).
- ADDR_HI, 32'h0000_2FFF, highest legal memory address (inclusive).
- CNT_W, 16, width of statistic counters.

Ports:
- clk  in  1  system clock, all state on posedge.
- reset  in  1  asynchronous, active-low reset (reset==0 clears all state immediately).
- char  in  8  ASCII character sampled every posedge.
- freq  in  16  clock frequency; power of two, >=2; stable during a record.
- format_type  out  2  0 none/invalid, 1 register record, 2 memory record.
- error_code  out  5  bit0 time, bit1 pc, bit2 addr, bit3 grf, bit4 time-regression.
- record_cnt  out  CNT_W  count of well-formed records, saturating.
- err_cnt  out  CNT_W  count of well-formed records with error_code!=0, saturating.

Behaviour:
- Reset values:
  - state IDLE;
  - format_type=0, error_code=0;
  - counters 0;
  - prev_time=0, prev_valid=0.
- FSM states and transitions (one char per posedge):
  - IDLE: '^' -> TIME.
  - TIME: 1..TIME_DIGITS decimal digits, then '@' -> PC.
  - PC: exactly 8 hex digits (0-9, a-f only), then ':' -> SP0.
  - SP0: 0+ spaces, then '$' -> GRF or '*' -> ADDR.
  - GRF: 1..GRF_DIGITS decimal digits.
  - ADDR: exactly 8 hex digits.
  - After GRF/ADDR: 0+ spaces, '<', '=' (adjacent), 0+ spaces.
  - DATA: exactly 8 hex digits, then '#' -> DONE.
- Any character not permitted in the current state -> IDLE, with one exception: '^' in any state restarts directly into TIME (accumulators cleared).
- Uppercase hex is illegal.
- Digit-count overflow (e.g. a 5th time digit) -> IDLE.
- DONE is one cycle long; its next-state rules are identical to IDLE.
- Outputs are combinational from registered state:
  - format_type and error_code are nonzero only while state==DONE, i.e. in the cycle after '#' is sampled.
  - They drop to 0 at the next posedge.
- Accumulators:
  - time: TIME_W=clog2(10^TIME_DIGITS) bits, value = value*10+digit.
  - grf: analogous width.
  - pc, addr: 32-bit shift-in, 4 bits per hex digit.
- Error bits (evaluated on captured values, registered with DONE):
  - bit0: time & ((freq>>1)-1) != 0.
  - bit1: pc<PC_LO, pc>PC_HI, or pc[1:0]!=0.
  - bit2 (memory records only): addr<ADDR_LO, addr>ADDR_HI, or addr[1:0]!=0.
  - bit3 (register records only): grf>=REG_NUM.
  - bit4: prev_valid && time<prev_time.
- Time history:
  - Every record reaching DONE sets prev_time=time and prev_valid=1, errors or not.
  - Malformed records never update prev_time.
- Counters:
  - record_cnt increments at the DONE entry.
  - err_cnt increments additionally if any error bit is set.
  - Both hold at 2^CNT_W-1.
- Back-to-back records: '^' sampled while in DONE starts a new record with no idle gap.
- reset asserted mid-record: the record is abandoned, counters and history are cleared.

Decomposition:
- Shared package cpu_checker_pkg:
  - state enum localparams;
  - error bit index constants (ERR_TIME..ERR_MONO);
  - format constants FMT_NONE/FMT_REG/FMT_MEM;
  - function pair is_dec/is_hex with digit value decode.
- One sub-module is natural: char_class (combinational: char -> is_dec, is_hex, nibble value).

Test Plan:
- freq=4096; `^2048@00003000: $5 <= 0000abcd#` -> cycle after '#': format_type=1, error_code=0; record_cnt=1, err_cnt=0.
- freq=4096; `^16@00003002:*00003000<=12345678#` -> format_type=2, error_code=5'b00111 (time, pc align, addr range); err_cnt=1.
- `^4096@00003000: $32 <= 00000000#` then `^2048@00003004: $1 <= 00000000#` with freq=4096 -> first error_code=5'b01000; second error_code=5'b10000.
- Malformed input:
  - `^12345@00003000: $1 <= 00000000#` (5 time digits);
  - `^1@0000300A: $1 <= 00000000#` (uppercase);
  - `<` followed by space then `=`.
  - Required: format_type=0 throughout; counters unchanged.
- `^1@00^2048@00003000: $0 <= 00000000#` -> restart on second '^'; format_type=1; record_cnt increments once.
- Drive reset=0 asynchronously mid-DATA -> immediately format_type=0, counters 0; subsequent valid record has bit4=0.
